// File: rtl/serial_pkg.sv
// Shared constants for the serial frame transmitter and detector benches.
// State encoding and default frame geometry live here so both sides agree.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_GAP   = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b10,
    StGap    = 2'b11
  } state_e;

endpackage

// File: rtl/serial_frame_tx.sv
// MSB-first parallel-to-serial framer with an optional idle gap between words.
// Define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] BitPen  = CntW'(WIDTH - 2);
  localparam logic [3:0]      GapLast = 4'((GAP > 0) ? GAP - 1 : 0);

  state_e            state_q;
  logic [WIDTH-1:0]  sreg_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [3:0]        gap_cnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q;
`endif

  // Outputs are registered alongside the state, so every branch sets the
  // values that will be visible in the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
      x          <= 1'b0;
      x_valid    <= 1'b0;
      din_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (din_valid) begin
            state_q    <= StShift;
            sreg_q     <= din;
            bit_cnt_q  <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q      <= ^din;
`endif
            x          <= din[WIDTH-1];
            x_valid    <= 1'b1;
            din_ready  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
          end
        end

        StShift: begin
          sreg_q <= sreg_q << 1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_q    <= StParity;
            x          <= par_q;
            x_valid    <= 1'b1;
            din_ready  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b1;
`else
            if (GAP > 0) begin
              state_q    <= StGap;
              gap_cnt_q  <= '0;
              x          <= 1'b0;
              x_valid    <= 1'b0;
              din_ready  <= 1'b0;
              busy       <= 1'b1;
              frame_done <= 1'b0;
            end else begin
              state_q    <= StIdle;
              x          <= 1'b0;
              x_valid    <= 1'b0;
              din_ready  <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b0;
            end
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            x         <= sreg_q[WIDTH-2];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            frame_done <= 1'b0;
`else
            frame_done <= (bit_cnt_q == BitPen);
`endif
          end
        end

        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q    <= StIdle;
            gap_cnt_q  <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            din_ready  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end

        default: begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          // Parity cycle: one bit, then the optional gap.
          if (GAP > 0) begin
            state_q    <= StGap;
            gap_cnt_q  <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            din_ready  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
          end else begin
            state_q    <= StIdle;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            din_ready  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end
`else
          state_q    <= StIdle;
          x          <= 1'b0;
          x_valid    <= 1'b0;
          din_ready  <= 1'b1;
          busy       <= 1'b0;
          frame_done <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: directed frames plus random traffic
// checked every cycle against a frame-position reference model.
module tb_serial_frame_tx;
  import serial_pkg::*;

  localparam int W = int'(DEFAULT_WIDTH);
  localparam int G = int'(DEFAULT_GAP);
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         x;
  logic         x_valid;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  // Model: position within the current frame (-1 = idle, 1 = first bit).
  int           phase = -1;
  logic [W-1:0] word  = '0;

  serial_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (phase %0d word %h)", tag, obs, exp, phase, word);
    end
  endtask

  task automatic check_outputs();
    logic ex, exv, erdy, ebusy, efd;
    if (phase < 0) begin
      {ex, exv, erdy, ebusy, efd} = 5'b00100;
    end else if (phase <= W) begin
      ex = word[W - phase]; exv = 1'b1; erdy = 1'b0; ebusy = 1'b1;
      efd = (phase == W) && (PAR == 0);
    end else if (phase <= FL) begin
      ex = ^word; exv = 1'b1; erdy = 1'b0; ebusy = 1'b1; efd = 1'b1;
    end else begin
      {ex, exv, erdy, ebusy, efd} = 5'b00010;
    end
    check1("x", x, ex);
    check1("x_valid", x_valid, exv);
    check1("din_ready", din_ready, erdy);
    check1("busy", busy, ebusy);
    check1("frame_done", frame_done, efd);
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    rst = r;
    din_valid = v;
    din = d;
    @(posedge clk);
    if (!r) begin
      phase = -1;
    end else if (phase < 0) begin
      if (v) begin
        phase = 1;
        word  = d;
      end
    end else begin
      phase++;
      if (phase > FL + G) phase = -1;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    int spacing;
    bit seen;

    // Reset held with din_valid asserted must not accept.
    step(1'b0, 1'b1, 8'hB4);
    step(1'b0, 1'b1, 8'hB4);

    // Single word.
    step(1'b1, 1'b1, 8'hB4);
    idle_steps(FL + G + 1);

    // Back-to-back with din_valid held high.
    step(1'b1, 1'b1, 8'hFF);
    spacing = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step(1'b1, 1'b1, 8'h00);
      if (din_ready === 1'b1) begin
        seen = 1'b1;
        spacing = k + 1;
      end
    end
    checks++;
    assert (seen && spacing == FL + G + 1) else begin
      errors++;
      $error("FAIL accept_spacing: observed %0d expected %0d", spacing, FL + G + 1);
    end
    step(1'b1, 1'b1, 8'h00);
    idle_steps(FL + G + 1);

    // Capture integrity: din changes mid-frame.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 8'hA5);
    for (int i = 0; i < FL + G; i++) step(1'b1, 1'b1, 8'h5A);
    idle_steps(1);

    // Mid-frame reset during bit 4, then a full frame.
    step(1'b1, 1'b1, 8'hF0);
    idle_steps(3);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h81);
    idle_steps(FL + G + 1);

    // Parity value check word (odd number of ones).
    step(1'b1, 1'b1, 8'h07);
    idle_steps(FL + G + 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end
    idle_steps(FL + G + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
